slt_seq32: RTL and testbench



---
 rtl/slt_seq32.sv | 130 +++++++++++++
 tb/tb_slt_seq32.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/slt_seq32.sv
// rtl/slt_seq32.sv - multi-cycle 32-bit set-less-than, one nibble per cycle MSB first
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      compare request, sampled only in IDLE
//   is_signed  1 = two's-complement compare, 0 = unsigned (sampled with start)
//   A, B       32-bit operands (sampled with start)
//   busy       high whenever the unit is not IDLE
//   done       registered one-cycle pulse, C updated on the same edge
//   C          32'd1 when A < B, else 32'd0; held until the next done
//
// Build option: SLT_SEQ32_EARLY_EXIT_EN leaves CMP at the first differing
// nibble (1-8 cycle latency); otherwise all 8 nibbles are scanned.

module slt_seq32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] C
);

`ifdef SLT_SEQ32_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [2:0]  idx;
  logic        lt_r;
  logic        decided_r;

  logic [3:0]  a_nib;
  logic [3:0]  b_nib;
  logic        dec_now;
  logic        lt_now;
  logic        last;

  // Once a decision is latched later nibbles cannot change it, so the
  // verdict for this cycle is either the held one or this nibble's.
  always_comb begin
    a_nib   = a_r[{idx, 2'b00} +: 4];
    b_nib   = b_r[{idx, 2'b00} +: 4];
    dec_now = decided_r;
    lt_now  = lt_r;
    if (!decided_r) begin
      if (a_nib < b_nib) begin
        dec_now = 1'b1;
        lt_now  = 1'b1;
      end else if (a_nib > b_nib) begin
        dec_now = 1'b1;
        lt_now  = 1'b0;
      end
    end
    last = (idx == 3'd0) || (EARLY_EXIT && dec_now);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_CMP;
      S_CMP:   if (last)  state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r       <= 32'd0;
      b_r       <= 32'd0;
      idx       <= 3'd0;
      lt_r      <= 1'b0;
      decided_r <= 1'b0;
      done      <= 1'b0;
      C         <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            // Flipping the sign bit of both operands maps two's-complement
            // ordering onto unsigned ordering.
            a_r       <= A ^ {is_signed, 31'd0};
            b_r       <= B ^ {is_signed, 31'd0};
            idx       <= 3'd7;
            lt_r      <= 1'b0;
            decided_r <= 1'b0;
          end
        end
        S_CMP: begin
          lt_r      <= lt_now;
          decided_r <= dec_now;
          idx       <= idx - 3'd1;
          if (last) begin
            C    <= {31'd0, lt_now};
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slt_seq32.sv
// tb/tb_slt_seq32.sv - randomized self-checking bench for slt_seq32

module tb_slt_seq32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] C;

  int chk_cnt;
  int err_cnt;

  slt_seq32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .C         (C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_slt(input logic [31:0] a, input logic [31:0] b, input logic s);
    if (s) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    return (a < b) ? 32'd1 : 32'd0;
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef SLT_SEQ32_EARLY_EXIT_EN
    for (int k = 7; k >= 0; k--) begin
      if (a[4*k +: 4] != b[4*k +: 4]) return 8 - k;
    end
`endif
    return 8;
  endfunction

  // Entered #1 after an edge with the unit idle; leaves it the same way.
  task automatic run_cmp(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag);
    int          n;
    bit          seen;
    logic [31:0] exp_c;
    exp_c = ref_slt(a, b, s);
    A = a;
    B = b;
    is_signed = s;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    check({tag, "_latency"}, n, ref_lat(a, b));
    check({tag, "_C"}, C, exp_c);
    check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_C_held"}, C, exp_c);
  endtask

  initial begin
    int          n_done;
    logic [31:0] c_at_done;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] mask;
    int          k;

    chk_cnt = 0;
    err_cnt = 0;
    rst_n = 1'b0;
    start = 1'b0;
    is_signed = 1'b0;
    A = 32'd0;
    B = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_C", C, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_cmp(32'h5D798A2B, 32'd10, 1'b0, "dir_big_small");
    run_cmp(32'd10, 32'h5D798A2B, 1'b0, "dir_small_big");
    run_cmp(32'h12345678, 32'h12345678, 1'b0, "dir_equal");
    run_cmp(32'hFFFFFFFF, 32'd1, 1'b1, "dir_m1_signed");
    run_cmp(32'hFFFFFFFF, 32'd1, 1'b0, "dir_m1_unsigned");
    run_cmp(32'h80000000, 32'h7FFFFFFF, 1'b1, "dir_min_max");
    run_cmp(32'h00000010, 32'h00000020, 1'b0, "dir_nib1");
    run_cmp(32'h10000000, 32'h20000000, 1'b0, "dir_nib7");
    run_cmp(32'h00000002, 32'h00000001, 1'b1, "dir_nib0");

    // A second start while busy must be dropped, not queued.
    A = 32'd3;
    B = 32'd5;
    is_signed = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n_done = 0;
    c_at_done = 32'hDEADBEEF;
    for (int i = 0; i < 24; i++) begin
      if (i == 2) begin
        A = 32'd5;
        B = 32'd3;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        c_at_done = C;
      end
    end
    start = 1'b0;
    check("busy_start_ndone", n_done, 32'd1);
    check("busy_start_C", c_at_done, 32'd1);
    check("busy_start_idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of a compare discards it with no done pulse.
    A = 32'd3;
    B = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_C", C, 32'd0);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check("midrst_no_done", n_done, 32'd0);
    run_cmp(32'd3, 32'd5, 1'b0, "after_rst");

    // Random operands sharing a random-length top prefix.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      k = int'($urandom_range(0, 8));
      if (k == 8) begin
        rb = ra;
      end else begin
        mask = (k == 7) ? 32'hFFFFFFFF : ((32'd1 << (4 * (k + 1))) - 32'd1);
        rb = (ra & ~mask) | ($urandom & mask);
      end
      if ($urandom_range(0, 1) == 1) run_cmp(ra, rb, 1'($urandom_range(0, 1)), "rnd");
      else run_cmp(rb, ra, 1'($urandom_range(0, 1)), "rnd");
    end

    $display("test done: total=%0d bad=%0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
